// File: rtl/b2p_array.sv
// Multi-channel binary-to-stochastic converter; a start latches words and seed, then a STREAM_LEN-bit burst follows one cycle later.
// Latency: first valid bit two edges after start. No backpressure; start is ignored while busy.
module b2p_array #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int STREAM_LEN = 256,
  parameter int ROT_STEP   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             seed,
  input  logic [CHANNELS*WIDTH-1:0]    binary_in,
  output logic [CHANNELS-1:0]          pulsed_out,
  output logic                         valid,
  output logic                         busy,
  output logic                         done
);
  localparam int CW = $clog2(STREAM_LEN + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                      state, state_nxt;
  logic [WIDTH-1:0]            lfsr;
  logic [CW-1:0]               cnt;
  logic [CHANNELS*WIDTH-1:0]   words;
  logic [CHANNELS-1:0]         cmp;
  logic                        fb;
  logic                        last;

  assign last = (cnt == CW'(STREAM_LEN - 1));
  assign busy = (state != IDLE);

  // Maximal-length taps for each supported width
  generate
    if (WIDTH == 8) begin : g_fb8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (WIDTH == 32) begin : g_fb32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_fb16
      assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end
  endgenerate

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int R = (i * ROT_STEP) % WIDTH;
    logic [WIDTH-1:0] rnd;
    if (R == 0) begin : g_norot
      assign rnd = lfsr;
    end else begin : g_rot
      assign rnd = {lfsr[WIDTH-1-R:0], lfsr[WIDTH-1 -: R]};
    end
    assign cmp[i] = (words[i*WIDTH +: WIDTH] > rnd);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulsed_out <= '0;
      valid      <= 1'b0;
      done       <= 1'b0;
      lfsr       <= ONE;
      cnt        <= '0;
      words      <= '0;
    end else begin
      case (state)
        IDLE: begin
          pulsed_out <= '0;
          valid      <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            words <= binary_in;
            lfsr  <= (seed == '0) ? ONE : seed;
            cnt   <= '0;
          end
        end
        RUN: begin
          pulsed_out <= cmp;
          valid      <= 1'b1;
          done       <= last;
          lfsr       <= {lfsr[WIDTH-2:0], fb};
          cnt        <= cnt + CW'(1);
        end
        default: begin
          pulsed_out <= '0;
          valid      <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_b2p_array.sv
// Directed bench for b2p_array: a 16-bit/4-channel/256-bit instance against a golden model
// and hand values, plus an 8-bit/1-channel/1-bit instance for the single-bit burst case.
module tb_b2p_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] seed;
  logic [63:0] binary_in;
  logic [3:0]  pulsed_out;
  logic        valid, busy, done;

  logic        s1_start;
  logic [7:0]  s1_seed, s1_bin;
  logic [0:0]  s1_pulsed;
  logic        s1_valid, s1_busy, s1_done;

  int errors = 0;
  int checks = 0;
  logic [3:0] cap  [256];
  logic [3:0] prev [256];

  localparam logic [63:0] W_MIX = 64'h0001_C000_8000_1234;

  b2p_array #(.WIDTH(16), .CHANNELS(4), .STREAM_LEN(256), .ROT_STEP(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .binary_in(binary_in),
    .pulsed_out(pulsed_out), .valid(valid), .busy(busy), .done(done)
  );

  b2p_array #(.WIDTH(8), .CHANNELS(1), .STREAM_LEN(1), .ROT_STEP(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .seed(s1_seed), .binary_in(s1_bin),
    .pulsed_out(s1_pulsed), .valid(s1_valid), .busy(s1_busy), .done(s1_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nxt16(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x};
    return (n == 0) ? x : d[31-n -: 16];
  endfunction

  function automatic logic [3:0] model_bits(input logic [15:0] s, input logic [63:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (w[i*16 +: 16] > rotl16(s, (i * 3) % 16));
    return r;
  endfunction

  // One burst: start, sample every cycle at negedge, compare against the model.
  // disturb pokes start/seed/binary_in mid-burst; abort_at resets on that valid cycle.
  task automatic burst(input string tag, input logic [15:0] sd, input logic [63:0] w,
                       input bit hold, input bit disturb, input int abort_at);
    logic [15:0] m;
    int nvalid, nbusy, ndone, done_idx, nmis, nz_bad;
    bit seen;
    m = (sd == 16'h0) ? 16'h1 : sd;
    nvalid = 0; nbusy = 0; ndone = 0; done_idx = 0; nmis = 0; nz_bad = 0; seen = 1'b0;
    seed = sd; binary_in = w; start = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold) start = 1'b0;
    chk({tag, " busy_after_start"}, {busy, valid}, 2'b10);
    if (busy) nbusy++;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
      if (!valid && pulsed_out != 4'h0) nz_bad++;
      if (valid) begin
        if (pulsed_out !== model_bits(m, w)) nmis++;
        if (nvalid < 256) cap[nvalid] = pulsed_out;
        nvalid++;
        m = nxt16(m);
        if (done) done_idx = nvalid;
        seen = 1'b1;
        if (disturb && nvalid == 50) begin start = 1'b1; binary_in = ~w; seed = 16'h5555; end
        if (disturb && nvalid == 53) start = 1'b0;
        if (abort_at != 0 && nvalid == abort_at) begin
          rst = 1'b1;
          @(posedge clk); @(negedge clk);
          rst = 1'b0;
          chk({tag, " outputs_after_rst"}, {pulsed_out, valid, busy, done}, 7'h0);
          chk({tag, " stream_before_rst"}, nmis, 0);
          @(posedge clk); @(negedge clk);
          chk({tag, " stays_idle"}, {valid, busy}, 2'b00);
          return;
        end
      end else if (seen) begin
        break;
      end
    end
    chk({tag, " nvalid"}, nvalid, 256);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_index"}, done_idx, 256);
    chk({tag, " busy_cycles"}, nbusy, 257);
    chk({tag, " stream"}, nmis, 0);
    chk({tag, " zero_when_invalid"}, nz_bad, 0);
  endtask

  task automatic s1_run(input string tag, input logic [7:0] sd, input logic [7:0] w, input logic bit_exp);
    s1_seed = sd; s1_bin = w; s1_start = 1'b1;
    @(posedge clk); @(negedge clk);
    s1_start = 1'b0;
    chk({tag, " accept"}, {s1_busy, s1_valid, s1_done}, 3'b100);
    @(posedge clk); @(negedge clk);
    chk({tag, " bit"}, {s1_busy, s1_valid, s1_done, s1_pulsed}, {3'b111, bit_exp});
    @(posedge clk); @(negedge clk);
    chk({tag, " end"}, {s1_busy, s1_valid, s1_done, s1_pulsed}, 4'b0000);
  endtask

  function automatic int diff_prev();
    int d = 0;
    for (int i = 0; i < 256; i++) if (cap[i] !== prev[i]) d++;
    return d;
  endfunction

  initial begin
    int d;
    rst = 1'b1; start = 1'b0; seed = 16'h0; binary_in = 64'h0;
    s1_start = 1'b0; s1_seed = 8'h0; s1_bin = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_main", {pulsed_out, valid, busy, done}, 7'h0);
    chk("reset_s1", {s1_pulsed, s1_valid, s1_busy, s1_done}, 4'h0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    burst("zero_words", 16'hACE1, 64'h0, 1'b0, 1'b0, 0);

    // Hand-derived: lfsr 0xACE1 then 0x59C3
    burst("mix_ace1", 16'hACE1, W_MIX, 1'b0, 1'b0, 0);
    chk("mix_ace1 bit0", cap[0], 4'b0110);
    chk("mix_ace1 bit1", cap[1], 4'b0100);

    burst("seed0", 16'h0000, W_MIX, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++) prev[i] = cap[i];
    burst("seed1", 16'h0001, W_MIX, 1'b0, 1'b0, 0);
    chk("seed0_vs_seed1 diff", diff_prev(), 0);
    chk("seed1 bit0", cap[0], 4'b0111);
    burst("seed1_repeat", 16'h0001, W_MIX, 1'b0, 1'b0, 0);
    chk("repeat diff", diff_prev(), 0);

    burst("half", 16'hACE1, {4{16'h8000}}, 1'b0, 1'b0, 0);
    chk("half bit0", cap[0], 4'b0110);
    d = 0;
    for (int i = 0; i < 256; i++) if (cap[i][0] !== cap[i][1]) d++;
    chk("half ch0_ch1_differ", (d != 0), 1'b1);

    // Start held high: exactly one idle cycle between bursts
    burst("cont_a", 16'h1D2F, W_MIX, 1'b1, 1'b0, 0);
    chk("cont idle_gap", {busy, start}, 2'b01);
    burst("cont_b", 16'h1D2F, W_MIX, 1'b0, 1'b0, 0);

    burst("disturb", 16'hBEEF, W_MIX, 1'b0, 1'b1, 0);
    burst("abort", 16'hACE1, W_MIX, 1'b0, 1'b0, 100);
    burst("after_abort", 16'hACE1, W_MIX, 1'b0, 1'b0, 0);

    s1_run("s1_ff", 8'h00, 8'hFF, 1'b1);
    s1_run("s1_equal", 8'h01, 8'h01, 1'b0);
    s1_run("s1_seed0_sub", 8'h00, 8'h01, 1'b0);
    s1_run("s1_two", 8'h00, 8'h02, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
